// File: rtl/lock_code_controller.sv
// rtl/lock_code_controller.sv - DigiLock code memory access master with verify scan and failed-attempt lockout
module lock_code_controller #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_slot,
  input  logic [15:0] cmd_code,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [1:0]  match_slot,
  output logic        locked,
  output logic [1:0]  mem_idx,
  output logic        mem_wr,
  output logic        mem_enable,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE,
    S_LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_op;
  logic [1:0]    r_slot;
  logic [15:0]   r_code;
  logic [1:0]    r_scan;
  logic [FW-1:0] r_fail_cnt;
  logic [LW-1:0] r_lock_cnt;
  logic          r_match;
  logic [1:0]    r_match_slot;
  logic          w_hit;
  logic [FW-1:0] w_fail_inc;
  logic          w_lock_now;

  // A zero candidate never matches, so empty (zero) slots can never report a hit.
  assign w_hit      = (mem_rdata == r_code) && (r_code != 16'h0000);
  assign w_fail_inc = r_fail_cnt + FW'(1);
  assign w_lock_now = !r_op && !r_match && (w_fail_inc == FAIL_LIMIT);

  assign match      = r_match;
  assign match_slot = r_match_slot;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus all status and memory-bus outputs decoded from the state.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    locked     = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_idx    = 2'd0;
    mem_wdata  = 16'h0000;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = cmd_op ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_idx    = r_slot;
        mem_wdata  = r_code;
        w_next     = S_DONE;
      end
      S_READ: begin
        mem_enable = 1'b1;
        mem_idx    = r_scan;
        if (w_hit || (r_scan == 2'd3)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = w_lock_now ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        locked = 1'b1;
        if (r_lock_cnt == LW'(1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, scan pointer, verify result, failure count and lockout timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 1'b0;
      r_slot       <= 2'd0;
      r_code       <= 16'h0000;
      r_scan       <= 2'd0;
      r_fail_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_match      <= 1'b0;
      r_match_slot <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cmd_op;
            r_slot <= cmd_slot;
            r_code <= cmd_code;
            r_scan <= 2'd0;
          end
        end
        S_READ: begin
          if (w_hit) begin
            r_match      <= 1'b1;
            r_match_slot <= r_scan;
          end else if (r_scan == 2'd3) begin
            r_match      <= 1'b0;
            r_match_slot <= 2'd0;
          end else begin
            r_scan <= r_scan + 2'd1;
          end
        end
        S_DONE: begin
          // STORE leaves the verify result and the failure count untouched.
          if (!r_op) begin
            if (r_match) begin
              r_fail_cnt <= '0;
            end else begin
              if (r_fail_cnt != FAIL_LIMIT) r_fail_cnt <= w_fail_inc;
              if (w_lock_now) r_lock_cnt <= LOCK_LOAD;
            end
          end
        end
        S_LOCKED: begin
          r_lock_cnt <= r_lock_cnt - LW'(1);
          if (r_lock_cnt == LW'(1)) r_fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_controller.sv
// tb/tb_lock_code_controller.sv - self-checking bench for lock_code_controller
module tb_lock_code_controller;

  localparam int MAX_FAILS = 3;
  localparam int LOCK_CYC  = 8;
  localparam int NVEC      = 15;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [1:0]  cmd_slot;
  logic [15:0] cmd_code;
  logic        busy;
  logic        done;
  logic        match;
  logic [1:0]  match_slot;
  logic        locked;
  logic [1:0]  mem_idx;
  logic        mem_wr;
  logic        mem_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  lock_code_controller #(.MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCK_CYC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .cmd_code(cmd_code), .busy(busy),
    .done(done), .match(match), .match_slot(match_slot), .locked(locked),
    .mem_idx(mem_idx), .mem_wr(mem_wr), .mem_enable(mem_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code memory stub: combinational read, write on the rising edge.
  logic [15:0] mem_array [4] = '{default: 16'h0000};
  always @(posedge clk) if (mem_enable && mem_wr) mem_array[mem_idx] <= mem_wdata;
  assign mem_rdata = (mem_enable && !mem_wr) ? mem_array[mem_idx] : 16'h0000;

  // Reference model state.
  logic [15:0] ref_mem [4] = '{default: 16'h0000};
  int          ref_fail  = 0;
  bit          ref_match = 1'b0;
  logic [1:0]  ref_mslot = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          op;
    logic [1:0]  slot;
    logic [15:0] code;
    bit          hold;
    bit          em;
    logic [1:0]  es;
    int          lat;
    bit          lock;
  } vec_t;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_match_slot"}, 32'(match_slot), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_mem"}, 32'({mem_enable, mem_wr, mem_idx, mem_wdata}), 32'd0);
  endtask

  task automatic model_reset();
    ref_fail  = 0;
    ref_match = 1'b0;
    ref_mslot = 2'd0;
  endtask

  // Issue one command and check every cycle until done, then any lockout window.
  task automatic do_cmd(input bit op, input logic [1:0] slot, input logic [15:0] code,
                        input bit hold, input bit em, input logic [1:0] es,
                        input int lat, input bit elock, input int abort_at);
    int reads;
    reads = op ? 0 : lat - 1;
    @(negedge clk);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    chk("locked_before_cmd", 32'(locked), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = slot;
    cmd_code  = code;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("ready_while_busy", 32'(cmd_ready), 32'd0);
      chk("done", 32'(done), 32'(n == lat));
      if (op && n == 1)
        chk("mem_write", 32'({mem_enable, mem_wr, mem_idx, mem_wdata}), 32'({2'b11, slot, code}));
      else if (!op && n <= reads)
        chk("mem_read", 32'({mem_enable, mem_wr, mem_idx}), 32'({2'b10, 2'(n - 1)}));
      else
        chk("mem_quiet", 32'({mem_enable, mem_wr, mem_idx, mem_wdata}), 32'd0);
      if (n == lat) begin
        chk("match", 32'(match), 32'(em));
        chk("match_slot", 32'(match_slot), 32'(es));
        cmd_valid = elock;
      end else begin
        chk("match_held", 32'(match), 32'(ref_match));
        cmd_valid = hold;
        cmd_op    = 1'($urandom);
        cmd_slot  = 2'($urandom);
        cmd_code  = 16'($urandom);
      end
    end
    if (op) ref_mem[slot] = code;
    else begin
      ref_match = em;
      ref_mslot = es;
      if (em) ref_fail = 0;
      else begin
        ref_fail++;
        if (ref_fail >= MAX_FAILS) ref_fail = 0;
      end
    end
    if (elock) begin
      for (int m = 1; m <= LOCK_CYC; m++) begin
        @(negedge clk);
        chk("locked", 32'(locked), 32'd1);
        chk("ready_locked", 32'(cmd_ready), 32'd0);
        chk("busy_locked", 32'(busy), 32'd1);
        chk("mem_locked", 32'({mem_enable, mem_wr, mem_idx, mem_wdata}), 32'd0);
        cmd_op   = 1'($urandom);
        cmd_code = 16'($urandom);
        if (m == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset     = 1'b0;
          cmd_valid = 1'b0;
          check_idle("rst_locked");
          model_reset();
          break;
        end
      end
    end
  endtask

  task automatic do_pred(input bit op, input logic [1:0] slot, input logic [15:0] code,
                         input bit hold, input int abort_at);
    bit         m;
    logic [1:0] s;
    int         lat;
    bit         lk;
    m = 1'b0; s = 2'd0; lat = 2;
    if (op) begin
      m = ref_match;
      s = ref_mslot;
    end else begin
      lat = 5;
      for (int i = 3; i >= 0; i--)
        if (code != 16'h0000 && ref_mem[i] == code) begin
          m = 1'b1; s = 2'(i); lat = 2 + i;
        end
    end
    lk = !op && !m && (ref_fail + 1 == MAX_FAILS);
    do_cmd(op, slot, code, hold, m, s, lat, lk, abort_at);
  endtask

  function automatic logic [15:0] pick_code();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'h1234;
      2:       return 16'hBEEF;
      3:       return 16'hA5A5;
      default: return (16'($urandom) & 16'h3FFF) | 16'h4000;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 5, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 16'h1234, 1'b1, 1'b0, 2'd0, 2, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 16'h1234, 1'b0, 1'b1, 2'd2, 4, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b1, 2'd2, 2, 1'b0};
    vecs[4]  = '{1'b1, 2'd3, 16'hBEEF, 1'b0, 1'b1, 2'd2, 2, 1'b0};
    vecs[5]  = '{1'b0, 2'd3, 16'hBEEF, 1'b0, 1'b1, 2'd1, 3, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 16'h9999, 1'b1, 1'b0, 2'd0, 5, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 16'h9999, 1'b0, 1'b0, 2'd0, 5, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 16'h1234, 1'b0, 1'b1, 2'd2, 4, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 16'h9999, 1'b1, 1'b0, 2'd0, 5, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 16'h9999, 1'b0, 1'b0, 2'd0, 5, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 16'h9999, 1'b0, 1'b0, 2'd0, 5, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 16'hBEEF, 1'b0, 1'b1, 2'd1, 3, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 16'h0000, 1'b0, 1'b1, 2'd1, 2, 1'b0};
    vecs[14] = '{1'b0, 2'd2, 16'hBEEF, 1'b0, 1'b1, 2'd3, 5, 1'b0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_slot  = 2'd0;
    cmd_code  = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    for (int i = 0; i < NVEC; i++)
      do_cmd(vecs[i].op, vecs[i].slot, vecs[i].code, vecs[i].hold,
             vecs[i].em, vecs[i].es, vecs[i].lat, vecs[i].lock, 0);

    for (int i = 0; i < 40; i++)
      do_pred(($urandom_range(0, 9) < 4), 2'($urandom), pick_code(), 1'($urandom), 0);

    // Leave a pending failure, then reset in the middle of a scan (scan=2).
    do_pred(1'b0, 2'd0, 16'h9999, 1'b0, 0);
    @(negedge clk);
    chk("ready_before_abort", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_code  = 16'h9999;
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("abort_scan_idx", 32'({mem_enable, mem_wr, mem_idx}), 32'({2'b10, 2'd2}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_read");
    model_reset();

    // Fail count was cleared: two misses stay unlocked, the third locks and is reset away.
    do_pred(1'b0, 2'd0, 16'h9999, 1'b0, 0);
    do_pred(1'b0, 2'd0, 16'h9999, 1'b0, 0);
    do_cmd(1'b0, 2'd0, 16'h9999, 1'b0, 1'b0, 2'd0, 5, 1'b1, 3);
    do_pred(1'b0, 2'd0, 16'h9999, 1'b0, 0);
    do_pred(1'b0, 2'd0, 16'h9999, 1'b0, 0);
    @(negedge clk);
    chk("final_unlocked", 32'(locked), 32'd0);
    chk("final_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
